// File: rtl/cpu_types_pkg.sv
// Shared CPU types: multiply/divide opcodes, the FSM state type and the
// operand-magnitude helper used by the iterative multiply/divide unit.
package cpu_types_pkg;

  localparam int MD_ITERS = 32;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } multdiv_op_t;

  typedef enum logic [1:0] {
    MD_S_IDLE   = 2'd0,
    MD_S_CALC   = 2'd1,
    MD_S_ADJUST = 2'd2,
    MD_S_DONE   = 2'd3
  } md_state_t;

  // Unsigned magnitude of an operand. The true magnitude of the most-negative
  // value needs WORD_W+1 bits, but its top bit is always clear, so the low
  // WORD_W bits of the two's-complement negation are exact (0x8000_0000 maps
  // to 0x8000_0000 read as unsigned).
  function automatic word_t magnitude(input word_t x, input logic is_signed);
    return (is_signed && x[$bits(word_t)-1]) ? word_t'(~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO registers.
// One FSM drives a shared 65-bit accumulator that either shift-adds
// (multiply) or shift-subtracts with restore (divide) on operand magnitudes;
// signs are reapplied in a single ADJUST cycle before HI/LO are written.
module mult_div_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  multdiv_op_t       op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);

  localparam int CNT_W = $clog2(WORD_W);

  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2*WORD_W:0] acc;       // {carry/remainder, low word}
  logic [2*WORD_W:0] acc_step;
  logic [WORD_W-1:0] opnd;      // multiplicand or divisor magnitude
  logic              is_div;
  logic              neg_q;     // negate product (mul) or quotient (div)
  logic              neg_r;     // negate remainder (div only)

  logic              signed_op;
  logic              div_op;
  logic [WORD_W:0]   mul_sum;
  logic [WORD_W:0]   div_rem;
  logic [WORD_W+1:0] div_diff;

  // Status decodes straight from state.
  assign busy = (state == MD_S_CALC) || (state == MD_S_ADJUST);
  assign done = (state == MD_S_DONE);

  // Classify the incoming opcode.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    div_op    = (op == MD_DIV)  || (op == MD_DIVU);
  end

  // One radix-2 iteration of the shared datapath.
  always_comb begin
    acc_step = acc;
    mul_sum  = '0;
    div_rem  = '0;
    div_diff = '0;
    if (is_div) begin
      // Restoring step: shift the partial remainder left by one, try to
      // subtract the divisor, keep the difference when it did not borrow.
      div_rem  = acc[2*WORD_W-1:WORD_W-1];
      div_diff = {1'b0, div_rem} - {2'b00, opnd};
      acc_step = {div_diff[WORD_W+1] ? div_rem : div_diff[WORD_W:0],
                  acc[WORD_W-2:0], ~div_diff[WORD_W+1]};
    end else begin
      // Shift-add step: add the multiplicand when the current multiplier
      // bit is set, then shift the whole product right by one.
      mul_sum  = acc[2*WORD_W:WORD_W] + {1'b0, opnd};
      acc_step = {1'b0, acc[0] ? mul_sum : acc[2*WORD_W:WORD_W],
                  acc[WORD_W-1:1]};
    end
  end

  // Control FSM plus all datapath and architectural registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the datapath registers are reset along with the control state;
      // they are few flops and this keeps the unit free of X after reset.
      state       <= MD_S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values regardless of statement order.
      unique case (state)
        MD_S_IDLE, MD_S_DONE: begin
          state <= MD_S_IDLE;
          if (start) begin
            unique case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                acc         <= {{(WORD_W+1){1'b0}},
                                magnitude(div_op ? a : b, signed_op)};
                opnd        <= magnitude(div_op ? b : a, signed_op);
                is_div      <= div_op;
                // A zero divisor returns the all-ones quotient unsigned.
                neg_q       <= signed_op && (a[WORD_W-1] ^ b[WORD_W-1]) &&
                               !(div_op && (b == '0));
                neg_r       <= signed_op && a[WORD_W-1];
                cnt         <= '0;
                div_by_zero <= 1'b0;
                state       <= MD_S_CALC;
              end
              MD_MTHI: begin
                hi          <= a;
                div_by_zero <= 1'b0;
              end
              MD_MTLO: begin
                lo          <= a;
                div_by_zero <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MD_S_CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WORD_W - 1)) state <= MD_S_ADJUST;
        end
        MD_S_ADJUST: begin
          if (is_div) begin
            lo <= neg_q ? -acc[WORD_W-1:0] : acc[WORD_W-1:0];
            hi <= neg_r ? -acc[2*WORD_W-1:WORD_W] : acc[2*WORD_W-1:WORD_W];
          end else begin
            {hi, lo} <= neg_q ? -acc[2*WORD_W-1:0] : acc[2*WORD_W-1:0];
          end
          div_by_zero <= is_div && (opnd == '0);
          state       <= MD_S_DONE;
        end
        default: state <= MD_S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases followed by
// randomized operations, compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  import cpu_types_pkg::*;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start;
  multdiv_op_t   op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int            total  = 0;
  int            passed = 0;

  // Reference architectural state.
  logic [W-1:0]  m_hi  = '0;
  logic [W-1:0]  m_lo  = '0;
  logic          m_dbz = 1'b0;

  mult_div_unit #(.WORD_W(W)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Architectural result of one accepted operation, from integer arithmetic.
  task automatic model(input multdiv_op_t o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    longint          sx, sy, q, r;
    longint unsigned p;
    m_dbz = 1'b0;
    case (o)
      MD_MULT: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = longint'(sx * sy);
        {m_hi, m_lo} = p;
      end
      MD_MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = p;
      end
      MD_DIV, MD_DIVU: begin
        if (y == '0) begin
          m_dbz = 1'b1;
          m_hi  = x;
          m_lo  = '1;
        end else begin
          if (o == MD_DIV) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
          end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
          end
          q    = sx / sy;
          r    = sx % sy;
          m_lo = q[W-1:0];
          m_hi = r[W-1:0];
        end
      end
      MD_MTHI: m_hi = x;
      MD_MTLO: m_lo = x;
      default: ;
    endcase
  endtask

  // Entered and left at a falling edge; the rising edge between is E0.
  task automatic start_op(input multdiv_op_t o, input logic [W-1:0] x,
                          input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Follows an accepted arithmetic op through to its DONE cycle.
  task automatic wait_result(input string tag, input multdiv_op_t o,
                             input logic [W-1:0] x, input logic [W-1:0] y,
                             input bit inject);
    logic [W-1:0] old_hi = m_hi;
    logic [W-1:0] old_lo = m_lo;
    int           cycles = 0;
    model(o, x, y);
    while (busy && cycles < 100) begin
      cycles++;
      if (cycles == 1) begin
        check({tag, " hi held"}, hi, old_hi);
        check({tag, " lo held"}, lo, old_lo);
      end
      start = inject && (cycles == 10);
      if (inject && cycles == 10) begin
        op = MD_MTHI;
        a  = 32'hCAFE_F00D;
      end
      @(negedge CLK);
    end
    start = 1'b0;
    check({tag, " busy cycles"}, cycles, 33);
    check({tag, " done"}, done, 1'b1);
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
    check({tag, " div_by_zero"}, div_by_zero, m_dbz);
  endtask

  task automatic idle_after(input string tag);
    @(negedge CLK);
    check({tag, " done drops"}, done, 1'b0);
    check({tag, " idle busy"}, busy, 1'b0);
  endtask

  task automatic mt_op(input string tag, input multdiv_op_t o,
                       input logic [W-1:0] x);
    model(o, x, '0);
    start_op(o, x, '0);
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
    check({tag, " no done"}, done, 1'b0);
    check({tag, " no busy"}, busy, 1'b0);
    check({tag, " div_by_zero"}, div_by_zero, m_dbz);
  endtask

  initial begin
    multdiv_op_t  ro;
    logic [W-1:0] rx, ry;

    nRST  = 1'b0;
    start = 1'b0;
    op    = MD_MULT;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge CLK);
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset dbz", div_by_zero, 1'b0);
    nRST = 1'b1;
    @(negedge CLK);

    start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu max hi const", hi, 32'hFFFF_FFFE);
    check("multu max lo const", lo, 32'h0000_0001);
    idle_after("multu max");

    start_op(MD_MULT, -32'sd7, 32'd3);
    wait_result("mult -7*3", MD_MULT, -32'sd7, 32'd3, 0);
    check("mult -7*3 lo const", lo, 32'hFFFF_FFEB);
    idle_after("mult -7*3");

    start_op(MD_DIV, -32'sd7, 32'd2);
    wait_result("div -7/2", MD_DIV, -32'sd7, 32'd2, 0);
    check("div -7/2 lo const", lo, 32'hFFFF_FFFD);
    check("div -7/2 hi const", hi, 32'hFFFF_FFFF);
    idle_after("div -7/2");

    // Second request held high in DONE is taken back-to-back.
    start_op(MD_DIVU, 32'd100, 32'd7);
    wait_result("divu 100/7", MD_DIVU, 32'd100, 32'd7, 0);
    start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div min/-1 lo const", lo, 32'h8000_0000);
    idle_after("div min/-1");

    start_op(MD_DIVU, 32'd5, 32'd0);
    wait_result("divu 5/0", MD_DIVU, 32'd5, 32'd0, 0);
    check("divu 5/0 flag const", div_by_zero, 1'b1);
    idle_after("divu 5/0");
    check("dbz held in idle", div_by_zero, 1'b1);
    mt_op("mthi", MD_MTHI, 32'hDEAD_BEEF);
    mt_op("mtlo", MD_MTLO, 32'h0BAD_F00D);

    start_op(MD_DIV, 32'h8000_0000, 32'd0);
    wait_result("div min/0", MD_DIV, 32'h8000_0000, 32'd0, 0);
    idle_after("div min/0");

    // An MTHI request during CALC must be ignored.
    start_op(MD_MULTU, 32'd3, 32'd5);
    wait_result("busy start ignored", MD_MULTU, 32'd3, 32'd5, 1);
    idle_after("busy start ignored");

    // Reset in the middle of CALC aborts without writing HI/LO.
    start_op(MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge CLK);
    check("midop busy", busy, 1'b1);
    nRST = 1'b0;
    #1;
    check("midop rst hi", hi, '0);
    check("midop rst lo", lo, '0);
    check("midop rst busy", busy, 1'b0);
    check("midop rst done", done, 1'b0);
    m_hi  = '0;
    m_lo  = '0;
    m_dbz = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("post rst idle", busy, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ro = multdiv_op_t'($urandom_range(0, 3));
      rx = $urandom;
      if ($urandom_range(0, 7) == 0)      ry = '0;
      else if ($urandom_range(0, 1) == 1) ry = $urandom;
      else                                ry = W'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0)      rx = 32'h8000_0000;
      start_op(ro, rx, ry);
      wait_result("random", ro, rx, ry, 0);
      if ($urandom_range(0, 1) == 1) idle_after("random");
    end
    idle_after("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
